// File: rtl/fb_pkg.sv
// Shared types and default geometry for the ping-pong block framebuffer.
// Combinational definitions only; no latency.
// No flow control of its own.
package fb_pkg;

  localparam int GRID_W_DEF  = 32;
  localparam int GRID_H_DEF  = 24;
  localparam int BLOCK_DEF   = 20;
  localparam int PIXEL_W_DEF = 8;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    PENDING = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_addr_map.sv
// Maps VGA counters to a linear block address and an in-grid flag.
// Purely combinational, zero latency.
// No flow control; follows the counters every cycle.
module fb_addr_map #(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int BLOCK  = 20,
  parameter int ADDR_W = 10
) (
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output logic [ADDR_W-1:0] raddr,
  output logic              in_grid
);

  localparam int X_LIMIT = GRID_W * BLOCK;
  localparam int Y_LIMIT = GRID_H * BLOCK;

  logic [31:0] bx;
  logic [31:0] by;

  // Constant division by the block edge; the address is only meaningful when in_grid is set.
  always_comb begin
    bx      = 32'(hc) / 32'(BLOCK);
    by      = 32'(vc) / 32'(BLOCK);
    in_grid = (32'(hc) < 32'(X_LIMIT)) && (32'(vc) < 32'(Y_LIMIT));
    raddr   = ADDR_W'(by * 32'(GRID_W) + bx);
  end

endmodule

// File: rtl/pingpong_framebuf.sv
// Double-buffered block framebuffer: writer fills back buffer, VGA scans front buffer upscaled.
// Read latency 1 clk from hc/vc to pixel_data_out; writes land in the back buffer the same clk.
// wr_ready drops during clear and while a swap waits for frame start; writes then are dropped.
module pingpong_framebuf
  import fb_pkg::*;
#(
  parameter int                 GRID_W      = GRID_W_DEF,
  parameter int                 GRID_H      = GRID_H_DEF,
  parameter int                 BLOCK       = BLOCK_DEF,
  parameter int                 PIXEL_W     = PIXEL_W_DEF,
  parameter logic [PIXEL_W-1:0] BLANK_COLOR = '0,
  parameter logic [PIXEL_W-1:0] CLEAR_COLOR = '0,
  localparam int                DEPTH       = GRID_W * GRID_H,
  localparam int                ADDR_W      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         vga_hc,
  input  logic [9:0]         vga_vc,
  output logic [PIXEL_W-1:0] pixel_data_out,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               wr_ready,
  output logic               wr_err,
  input  logic               frame_done,
  input  logic               clear_req,
  output logic               swap_pending,
  output logic               swapped,
  output logic               clear_busy,
  output logic               front_sel
);

  logic [PIXEL_W-1:0] mem0 [DEPTH];
  logic [PIXEL_W-1:0] mem1 [DEPTH];

  fb_state_e          state, state_nxt;
  logic [ADDR_W-1:0]  clr_cnt;
  logic               swap_latched;

  logic [ADDR_W-1:0]  raddr;
  logic               in_grid;

  logic               frame_start;
  logic               wr_accept;
  logic               wr_in_range;
  logic               clr_last;
  logic               do_swap;

  logic               bk_we;
  logic [ADDR_W-1:0]  bk_addr;
  logic [PIXEL_W-1:0] bk_dat;

  fb_addr_map #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .BLOCK  (BLOCK),
    .ADDR_W (ADDR_W)
  ) u_addr_map (
    .hc      (vga_hc),
    .vc      (vga_vc),
    .raddr   (raddr),
    .in_grid (in_grid)
  );

  assign frame_start  = (vga_hc == 10'd0) && (vga_vc == 10'd0);
  assign wr_ready     = (state == IDLE);
  assign swap_pending = (state == PENDING);
  assign clear_busy   = (state == CLEAR);
  assign wr_accept    = wr_en && wr_ready;
  assign wr_in_range  = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign clr_last     = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign do_swap      = (state == PENDING) && frame_start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: clear wins over a same-cycle swap request, which is remembered for after the clear.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_req)       state_nxt = CLEAR;
        else if (frame_done) state_nxt = PENDING;
      end
      CLEAR: begin
        if (clr_last) state_nxt = (swap_latched || frame_done) ? PENDING : IDLE;
      end
      PENDING: begin
        if (frame_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sweep counter, deferred swap flag, buffer select and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt      <= '0;
      swap_latched <= 1'b0;
      front_sel    <= 1'b0;
      swapped      <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      clr_cnt      <= (state == CLEAR) ? clr_cnt + ADDR_W'(1) : '0;
      if (state == IDLE)                    swap_latched <= frame_done;
      else if (state == CLEAR && frame_done) swap_latched <= 1'b1;
      front_sel    <= front_sel ^ do_swap;
      swapped      <= do_swap;
      wr_err       <= wr_accept && !wr_in_range;
    end
  end

  // Single back-buffer write port shared between the clear sweep and the writer.
  always_comb begin
    bk_we   = 1'b0;
    bk_addr = wr_addr;
    bk_dat  = wr_data;
    if (state == CLEAR) begin
      bk_we   = 1'b1;
      bk_addr = clr_cnt;
      bk_dat  = CLEAR_COLOR;
    end else if (wr_accept && wr_in_range) begin
      bk_we = 1'b1;
    end
  end

  // Buffer 0 is written only while it is the back buffer.
  always_ff @(posedge clk) begin
    if (bk_we && front_sel) mem0[bk_addr] <= bk_dat;
  end

  // Buffer 1 is written only while it is the back buffer.
  always_ff @(posedge clk) begin
    if (bk_we && !front_sel) mem1[bk_addr] <= bk_dat;
  end

  // Registered front-buffer read, blanked outside the grid.
  always_ff @(posedge clk) begin
    if (rst)           pixel_data_out <= BLANK_COLOR;
    else if (!in_grid) pixel_data_out <= BLANK_COLOR;
    else if (front_sel) pixel_data_out <= mem1[raddr];
    else               pixel_data_out <= mem0[raddr];
  end

endmodule
